// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with WAIT access cycles per transaction.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default is fixed priority, data over instruction.
module mem_arbiter #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic [3:0]  m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        grant_data;

  // last_q and gnt_q encode the port: 1 = data, 0 = instruction
  always_comb begin
    grant_data = 1'b0;
    if (d_req && !i_req) begin
      grant_data = 1'b1;
    end else if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
      grant_data = ~last_q;
`else
      grant_data = 1'b1;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = grant_data;
          last_d  = grant_data;
          addr_d  = grant_data ? d_addr : i_addr;
          wdata_d = grant_data ? d_wdata : 32'h0;
          we_d    = grant_data ? d_we : 4'h0;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'h0) begin
          if (gnt_q) d_rdata_d = m_rdata;
          else       i_rdata_d = m_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'h1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'h0;
      last_q    <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      we_q      <= 4'h0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // The counter still holds its load value only in the first ACCESS cycle, so a store writes once
  always_comb begin
    m_en    = (state_q == ACCESS);
    m_we    = (m_en && cnt_q == CNT_INIT) ? we_q : 4'h0;
    m_addr  = m_en ? addr_q : 32'h0;
    m_wdata = m_en ? wdata_q : 32'h0;
    i_ack   = (state_q == RESP) && !gnt_q;
    d_ack   = (state_q == RESP) && gnt_q;
    i_rdata = i_rdata_q;
    d_rdata = d_rdata_q;
    stall   = (i_req && !i_ack) || (d_req && !d_ack);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for contention, reset during an access and a request dropped mid-access.
module tb_mem_arbiter;

  localparam int W = 2;

  logic        clk, rst;
  logic        i_req, d_req;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_we;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ack, d_ack;
  logic        m_en;
  logic [3:0]  m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_d;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          chk;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mem [0:255];

  mem_arbiter #(.WAIT(W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple single-port memory: combinational read, byte-enabled write on the clock edge
  assign m_rdata = mem[m_addr[9:2]];

  always @(posedge clk) begin
    if (m_en) begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected response and checks port and data
  always @(negedge clk) begin : monitor
    exp_t e;
    if (i_ack && d_ack) checkOutput("both_acks", 32'(i_ack & d_ack), 32'h0);
    else if (i_ack || d_ack) begin
      if (sb.size() == 0) checkOutput("unexpected_ack", 32'(sb.size()), 32'h1);
      else begin
        e = sb.pop_front();
        checkOutput("ack_port", 32'(d_ack), 32'(e.is_d));
        if (e.chk) checkOutput("rdata", d_ack ? d_rdata : i_rdata, e.data);
      end
    end
  end

  // One isolated transaction: checks latency, m_en/m_we cycle counts, address and stall
  task automatic applyStimulus(input vec_t v);
    int lat = 0, en_cnt = 0, we_cnt = 0, addr_bad = 0;
    logic [3:0] we_seen = 4'h0;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    sb.push_back('{v.is_d, v.exp_rdata, v.chk});
    #1 checkOutput("stall_on_req", 32'(stall), 32'h1);
    for (int n = 1; n <= W + 8; n++) begin
      @(negedge clk);
      if (m_en) begin
        en_cnt++;
        if (m_addr !== v.addr) addr_bad++;
      end
      if (m_we != 4'h0) begin
        we_cnt++;
        we_seen = m_we;
      end
      if (i_ack || d_ack) begin
        lat = n;
        checkOutput("stall_at_ack", 32'(stall), 32'h0);
        i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
        break;
      end
    end
    checkOutput("latency", lat, W + 1);
    checkOutput("m_en_cycles", en_cnt, W);
    checkOutput("m_we_cycles", we_cnt, (v.we != 4'h0) ? 1 : 0);
    checkOutput("m_addr", addr_bad, 0);
    if (v.we != 4'h0) checkOutput("m_we_value", 32'(we_seen), 32'(v.we));
    i_req = 1'b0; d_req = 1'b0; d_we = 4'h0;
  endtask

  // Both ports held for 12 accesses; the loser must keep stalling
  task automatic contention();
    int acks = 0, i_n = 0, d_n = 0;
    for (int k = 0; k < 12; k++) begin
`ifdef MEM_ARB_RR_EN
      if (k % 2 == 0) sb.push_back('{1'b1, 32'hFF223344, 1'b1});
      else            sb.push_back('{1'b0, 32'h20080005, 1'b1});
`else
      sb.push_back('{1'b1, 32'hFF223344, 1'b1});
`endif
    end
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h10;
    for (int n = 0; n < 12 * (W + 2) + 10; n++) begin
      @(negedge clk);
      if (i_ack || d_ack) begin
        acks++;
        if (i_ack) i_n++;
        if (d_ack) d_n++;
        if (acks < 12) checkOutput("loser_stall", 32'(stall), 32'h1);
        if (acks == 12) break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checkOutput("cont_acks", acks, 12);
`ifdef MEM_ARB_RR_EN
    checkOutput("cont_i_grants", i_n, 6);
    checkOutput("cont_d_grants", d_n, 6);
`else
    checkOutput("cont_i_grants", i_n, 0);
    checkOutput("cont_d_grants", d_n, 12);
`endif
  endtask

  // Reset in the second ACCESS cycle of a read discards it; a fresh read then works
  task automatic resetMidAccess();
    int stray = 0;
    vec_t v;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    @(negedge clk);
    checkOutput("rst_access1_m_en", 32'(m_en), 32'h1);
    @(negedge clk);
    #1 rst = 1'b1; i_req = 1'b0;
    #1;
    checkOutput("rst_m_en", 32'(m_en), 32'h0);
    checkOutput("rst_i_ack", 32'(i_ack), 32'h0);
    checkOutput("rst_d_ack", 32'(d_ack), 32'h0);
    checkOutput("rst_m_addr", m_addr, 32'h0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 2 * W + 4; n++) begin
      @(negedge clk);
      if (i_ack || d_ack) stray++;
    end
    checkOutput("no_stray_ack", stray, 0);
    v = '{1'b0, 4'h0, 32'h3FC, 32'h0, 32'hCAFEF00D, 1'b1};
    applyStimulus(v);
  endtask

  // d_req dropped in the first ACCESS cycle: the ack still comes, then the pending fetch
  task automatic dropRequest();
    int d_lat = 0, i_lat = 0;
    sb.push_back('{1'b1, 32'h0000AB07, 1'b1});
    sb.push_back('{1'b0, 32'h20080005, 1'b1});
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 4'h0; d_addr = 32'h54;
    @(negedge clk);
    d_req = 1'b0;
    for (int n = 2; n < 4 * W + 12; n++) begin
      @(negedge clk);
      if (d_ack) d_lat = n;
      if (i_ack) begin
        i_lat = n;
        i_req = 1'b0;
        break;
      end
    end
    i_req = 1'b0;
    checkOutput("drop_d_latency", d_lat, W + 1);
    checkOutput("drop_i_latency", i_lat, 2 * W + 3);
  endtask

  initial begin
    vec_t tbl [9];
    tbl[0] = '{1'b0, 4'h0, 32'h004, 32'h00000000, 32'h20080005, 1'b1};
    tbl[1] = '{1'b1, 4'hF, 32'h054, 32'h00000007, 32'h0,        1'b0};
    tbl[2] = '{1'b1, 4'h0, 32'h054, 32'h0,        32'h00000007, 1'b1};
    tbl[3] = '{1'b1, 4'h2, 32'h054, 32'h0000AB00, 32'h0,        1'b0};
    tbl[4] = '{1'b1, 4'h0, 32'h054, 32'h0,        32'h0000AB07, 1'b1};
    tbl[5] = '{1'b0, 4'h0, 32'h054, 32'h0,        32'h0000AB07, 1'b1};
    tbl[6] = '{1'b1, 4'h8, 32'h010, 32'hFF000000, 32'h0,        1'b0};
    tbl[7] = '{1'b1, 4'h0, 32'h010, 32'h0,        32'hFF223344, 1'b1};
    tbl[8] = '{1'b0, 4'h0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b1};

    for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    mem[1]   <= 32'h20080005;
    mem[4]   <= 32'h11223344;
    mem[255] <= 32'hCAFEF00D;

    rst = 1'b1;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

    #2;
    checkOutput("reset_i_ack", 32'(i_ack), 32'h0);
    checkOutput("reset_d_ack", 32'(d_ack), 32'h0);
    checkOutput("reset_m_en", 32'(m_en), 32'h0);
    checkOutput("reset_m_we", 32'(m_we), 32'h0);
    checkOutput("reset_m_addr", m_addr, 32'h0);
    checkOutput("reset_m_wdata", m_wdata, 32'h0);
    checkOutput("reset_i_rdata", i_rdata, 32'h0);
    checkOutput("reset_d_rdata", d_rdata, 32'h0);
    checkOutput("reset_stall_idle", 32'(stall), 32'h0);
    d_req = 1'b1;
    #1 checkOutput("reset_stall_req", 32'(stall), 32'h1);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(tbl[i]);
    contention();
    resetMidAccess();
    dropRequest();

    repeat (W + 4) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter and access sequencer for the MIPS core. It shares a single unified memory port between instruction fetch and load/store. It also inserts a programmable number of wait states per access and raises `stall` so the pipeline freezes until its access completes. It sits between `mips` and a single-ported memory, and replaces the separate instruction and data memory paths when a unified memory is used.

## Interface
Parameters:
- `WAIT`, default 2: memory access cycles per transaction, legal range 1..15.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_req` in 1: instruction fetch request; held until `i_ack`.
- `i_addr` in 32: fetch byte address; word-aligned.
- `i_rdata` out 32: fetched instruction; valid while `i_ack`=1.
- `i_ack` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request; held until `d_ack`.
- `d_we` in 4: byte write enables; 0 means read.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_rdata` out 32: load data; valid while `d_ack`=1.
- `d_ack` out 1: one-cycle completion pulse for data.
- `m_en` out 1: memory enable.
- `m_we` out 4: memory byte write enables.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_rdata` in 32: memory read data.
- `stall` out 1: pipeline freeze, equal to `(i_req & ~i_ack) | (d_req & ~d_ack)`; combinational.

## Operation
- FSM states:
  - IDLE: no grant.
  - ACCESS: memory cycles for the granted request.
  - RESP: ack pulse.
- IDLE, no request: stays in IDLE.
- IDLE, one request: grants that requester, latches its address, wdata and we into internal registers, loads `cnt`=WAIT-1, and goes to ACCESS.
- IDLE, both requesting: the grant follows the arbitration policy (see Configuration).
- ACCESS:
  - `m_en`=1, `m_addr` and `m_wdata` driven from the latched registers.
  - `m_we` equals the latched we in the first ACCESS cycle only, and is 0 afterwards, so each store writes exactly once.
  - `cnt` decrements each cycle. At `cnt`=0, `m_rdata` is captured into the response register of the granted port and the FSM goes to RESP.
- RESP:
  - The granted port's ack is 1 for exactly one cycle, and its rdata shows the captured word.
  - `m_en`=0.
  - Next state is IDLE unconditionally.
- A write grant still captures `m_rdata`; requesters ignore it.
- Dropping `req` before ack does not abort the access: ACCESS and RESP complete and the ack still pulses.
- Request inputs are sampled only in IDLE. Changes to address or data after the grant are ignored.
- The `last` register records the port granted most recently and is updated on every grant.

## Timing
- Reset values: `i_ack`, `d_ack` and `m_en` are 0. `m_we`, `m_addr`, `m_wdata`, `i_rdata` and `d_rdata` are 0. `stall` follows its equation. State is IDLE, `cnt`=0, and `last` is instruction.
- Latency: with the request sampled in IDLE at edge N, ACCESS occupies cycles N+1..N+WAIT and the ack is high in cycle N+WAIT+1.
- Throughput: WAIT+2 cycles per access (IDLE, WAIT×ACCESS, RESP). Back-to-back requests from the same port lose no further cycles.
- `m_rdata` must be valid at the edge ending the last ACCESS cycle. The memory must meet this within WAIT cycles.
- Simultaneous requests in IDLE: exactly one grant. The loser's `stall` stays 1 and it is granted on the next IDLE.
- Reset asserted mid-ACCESS: all outputs return to reset values immediately (asynchronous). An in-flight read is discarded. A store whose first ACCESS edge has already passed stays written; otherwise it is not performed.
- WAIT=1: ACCESS lasts one cycle; `m_we` and the capture happen in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On contention the grant goes to the port not equal to `last`. The first contention after reset grants data.
- `MEM_ARB_RR_EN` undefined: fixed priority, data over instruction. `last` is still maintained but unused.

## Test plan
- Reset, then `i_req`=1 with `i_addr`=0x04 and `m_rdata`=0x20080005, WAIT=2: `m_en` is high for 2 cycles, `i_ack` pulses at cycle 4 with `i_rdata`=0x20080005, and `stall` drops in that cycle.
- Store with `d_we`=4'hF, `d_addr`=0x54, `d_wdata`=7, WAIT=3: `m_we`=4'hF for exactly 1 cycle, `m_en` for 3 cycles, `d_ack` at cycle 5, and `i_ack` stays 0.
- `i_req` and `d_req` held high continuously for 12 accesses:
  - Without the macro: all grants go to data and `i_ack` is never asserted.
  - With the macro: grants alternate D, I, D, I…, 6 each.
- Reset asserted in the 2nd ACCESS cycle of a read: `m_en` and both acks go to 0 within the same cycle. After release, a fresh request completes normally with the WAIT+1 latency.
- `d_req` dropped in the first ACCESS cycle: `d_ack` still pulses at N+WAIT+1, and the next IDLE grants a pending `i_req`.
